// File: rtl/mem_writeback_tag_allocator.sv
// mem_writeback_tag_allocator: issues age-ordered writeback tags, retires them in any order, tracks pending registers.
// Optional Flush port and behaviour enabled by defining MEM_WRITEBACK_TAG_FLUSH_EN.
module mem_writeback_tag_allocator #(
  parameter int TAGBITWIDTH     = 6,
  parameter int REGADDRBITWIDTH = 4
) (
  input  logic                            clk,
  input  logic                            async_rst_n,
  input  logic                            clk_en,
`ifdef MEM_WRITEBACK_TAG_FLUSH_EN
  input  logic                            Flush,
`endif
  input  logic                            AllocREQ,
  input  logic [REGADDRBITWIDTH-1:0]      AllocAddrIn,
  output logic                            AllocACK,
  output logic [TAGBITWIDTH-1:0]          AllocTag,
  input  logic                            ReleaseEn,
  input  logic [TAGBITWIDTH-1:0]          ReleaseTag,
  output logic                            ReleaseErr,
  output logic [TAGBITWIDTH-1:0]          OldestTag,
  output logic [TAGBITWIDTH-1:0]          FreeCount,
  output logic                            Full,
  output logic                            Empty,
  output logic [2**REGADDRBITWIDTH-1:0]   RegPendingMask
);
  localparam int IW    = TAGBITWIDTH - 1;
  localparam int DEPTH = 2 ** IW;
  localparam int NREG  = 2 ** REGADDRBITWIDTH;

  logic [TAGBITWIDTH-1:0]     r_head, r_tail;
  logic [DEPTH-1:0]           r_valid;
  logic [REGADDRBITWIDTH-1:0] r_addr [DEPTH];
  logic                       r_err;

  logic [TAGBITWIDTH-1:0]     w_outstanding, w_rel_age;
  logic [IW-1:0]              w_rel_idx, w_head_idx, w_tail_idx;
  logic                       w_flush, w_rel_ok, w_rel_hit, w_rel_err, w_tail_adv;
  logic [NREG-1:0]            w_mask;

`ifdef MEM_WRITEBACK_TAG_FLUSH_EN
  assign w_flush = clk_en & Flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_head_idx    = r_head[IW-1:0];
  assign w_tail_idx    = r_tail[IW-1:0];
  assign w_rel_idx     = ReleaseTag[IW-1:0];
  assign w_outstanding = r_head - r_tail;
  // Age relative to the tail; a tag is live only if it sits inside [tail, head).
  assign w_rel_age     = ReleaseTag - r_tail;
  assign w_rel_ok      = ReleaseEn & clk_en & r_valid[w_rel_idx] & (w_rel_age < w_outstanding);
  assign w_rel_hit     = w_rel_ok & ~w_flush;
  assign w_rel_err     = ReleaseEn & clk_en & ~w_flush & ~w_rel_ok;
  assign w_tail_adv    = (r_tail != r_head) & ~r_valid[w_tail_idx];

  assign FreeCount = TAGBITWIDTH'(DEPTH) - w_outstanding;
  assign Full      = FreeCount == '0;
  assign Empty     = r_head == r_tail;
  assign AllocACK  = clk_en & AllocREQ & ~Full & async_rst_n & ~w_flush;
  assign AllocTag  = r_head;
  assign OldestTag = r_tail;
  assign ReleaseErr = r_err;
  assign RegPendingMask = w_mask;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_valid[i]) w_mask[r_addr[i]] = 1'b1;
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_rel_err;
      if (clk_en) begin
        if (w_flush) begin
          r_valid <= '0;
          r_tail  <= r_head;
        end else begin
          if (w_tail_adv) r_tail <= r_tail + TAGBITWIDTH'(1);
          if (w_rel_hit) r_valid[w_rel_idx] <= 1'b0;
          if (AllocACK) r_valid[w_head_idx] <= 1'b1;
        end
        if (AllocACK) r_head <= r_head + TAGBITWIDTH'(1);
      end
    end
  end

  // Address storage needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk)
    if (AllocACK) r_addr[w_head_idx] <= AllocAddrIn;
endmodule

// File: tb/tb_mem_writeback_tag_allocator.sv
// tb_mem_writeback_tag_allocator: directed and randomized checks against a queue-based tag model.
module tb_mem_writeback_tag_allocator;
  logic        clk = 0, async_rst_n = 0, clk_en = 1, AllocREQ = 0, ReleaseEn = 0, Flush = 0;
  logic [3:0]  AllocAddrIn = 0;
  logic [5:0]  ReleaseTag = 0;
  logic        AllocACK, ReleaseErr, Full, Empty;
  logic [5:0]  AllocTag, OldestTag, FreeCount;
  logic [15:0] RegPendingMask;
  int total = 0, bad = 0;

  typedef struct {logic [5:0] tag; logic [3:0] addr; bit done;} ent_t;
  ent_t       mq[$];
  logic [5:0] m_next = 0;
  bit         m_err = 0;

  always #5 clk = ~clk;

  mem_writeback_tag_allocator dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
`ifdef MEM_WRITEBACK_TAG_FLUSH_EN
    .Flush(Flush),
`endif
    .AllocREQ(AllocREQ), .AllocAddrIn(AllocAddrIn), .AllocACK(AllocACK), .AllocTag(AllocTag),
    .ReleaseEn(ReleaseEn), .ReleaseTag(ReleaseTag), .ReleaseErr(ReleaseErr),
    .OldestTag(OldestTag), .FreeCount(FreeCount), .Full(Full), .Empty(Empty),
    .RegPendingMask(RegPendingMask)
  );

  function automatic bit m_live(input logic [5:0] t);
    foreach (mq[j]) if (mq[j].tag == t && !mq[j].done) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] m_oldest();
    return mq.size() > 0 ? mq[0].tag : m_next;
  endfunction

  function automatic logic [15:0] m_mask();
    logic [15:0] m = 0;
    foreach (mq[j]) if (!mq[j].done) m[mq[j].addr] = 1'b1;
    return m;
  endfunction

  function automatic logic [5:0] m_free();
    return 6'(32 - mq.size());
  endfunction

  task automatic drive(input bit req, input logic [3:0] addr, input bit ren, input logic [5:0] rtag);
    AllocREQ = req; AllocAddrIn = addr; ReleaseEn = ren; ReleaseTag = rtag;
    #1;
  endtask

  task automatic tick();
    bit         fl  = clk_en && Flush;
    bit         ack = clk_en && AllocREQ && mq.size() < 32 && !Flush;
    bit         rok = ReleaseEn && clk_en && m_live(ReleaseTag);
    bit         ren = ReleaseEn;
    logic [5:0] rt  = ReleaseTag;
    logic [3:0] ad  = AllocAddrIn;
    @(posedge clk);
    if (fl) mq.delete();
    else if (clk_en) begin
      if (mq.size() > 0 && mq[0].done) void'(mq.pop_front());
      if (rok) foreach (mq[j]) if (mq[j].tag == rt) mq[j].done = 1;
      if (ack) begin
        mq.push_back('{m_next, ad, 1'b0});
        m_next = m_next + 6'd1;
      end
    end
    m_err = ren && clk_en && !rok && !fl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    async_rst_n = 0;
    drive(0, 0, 0, 0);
    mq.delete(); m_next = 0; m_err = 0;
    #2 async_rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 4'(i), 0, 0); tick(); end
    total++; if (RegPendingMask !== 16'h0007) begin bad++; $display("FAIL pre_reset_mask got=%h want=0007", RegPendingMask); end
    #2 async_rst_n = 0;
    drive(1, 4'd5, 0, 0);
    total++; if (FreeCount !== 6'd32) begin bad++; $display("FAIL reset_free got=%0d want=32", FreeCount); end
    total++; if (Empty !== 1'b1 || Full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b want=1,0", Empty, Full); end
    total++; if (OldestTag !== 6'h00 || AllocTag !== 6'h00) begin bad++; $display("FAIL reset_tags oldest=%h alloc=%h want=00", OldestTag, AllocTag); end
    total++; if (RegPendingMask !== 16'h0 || AllocACK !== 1'b0 || ReleaseErr !== 1'b0) begin bad++; $display("FAIL reset_outs mask=%h ack=%b err=%b want=0", RegPendingMask, AllocACK, ReleaseErr); end
    mq.delete(); m_next = 0; m_err = 0;
    @(negedge clk);
    drive(0, 0, 0, 0);
    async_rst_n = 1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 4'(i % 16), 0, 0);
      total++; if (AllocACK !== 1'b1 || AllocTag !== 6'(i)) begin bad++; $display("FAIL fill_ack i=%0d ack=%b tag=%h want=1,%h", i, AllocACK, AllocTag, 6'(i)); end
      tick();
    end
    total++; if (Full !== 1'b1 || FreeCount !== 6'd0) begin bad++; $display("FAIL fill_full full=%b free=%0d want=1,0", Full, FreeCount); end
    total++; if (RegPendingMask !== 16'hFFFF) begin bad++; $display("FAIL fill_mask got=%h want=FFFF", RegPendingMask); end
    drive(1, 0, 0, 0);
    total++; if (AllocACK !== 1'b0) begin bad++; $display("FAIL fill_33rd ack=%b want=0", AllocACK); end
    tick();
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 4'(i + 4), 0, 0); tick(); end
    drive(0, 0, 1, 6'd1); tick();
    drive(0, 0, 0, 0); tick();
    total++; if (OldestTag !== 6'd0 || FreeCount !== 6'd29) begin bad++; $display("FAIL ooo_hold oldest=%0d free=%0d want=0,29", OldestTag, FreeCount); end
    total++; if (RegPendingMask !== 16'h0050) begin bad++; $display("FAIL ooo_mask got=%h want=0050", RegPendingMask); end
    drive(0, 0, 1, 6'd0); tick();
    drive(0, 0, 0, 0); tick();
    total++; if (OldestTag !== 6'd1) begin bad++; $display("FAIL ooo_step1 oldest=%0d want=1", OldestTag); end
    tick();
    total++; if (OldestTag !== 6'd2 || FreeCount !== 6'd31) begin bad++; $display("FAIL ooo_step2 oldest=%0d free=%0d want=2,31", OldestTag, FreeCount); end
  endtask

  task automatic test_wrap();
    logic [5:0] fc, ot;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1, 4'($urandom), i > 0, 6'(i - 1));
      total++; if (AllocACK !== 1'b1 || AllocTag !== 6'(i)) begin bad++; $display("FAIL wrap_tag i=%0d ack=%b tag=%h want=1,%h", i, AllocACK, AllocTag, 6'(i)); end
      tick();
    end
    fc = FreeCount; ot = OldestTag;
    drive(0, 0, 1, 6'h00); tick();
    drive(0, 0, 0, 0);
    total++; if (ReleaseErr !== 1'b1) begin bad++; $display("FAIL wrap_stale_err got=%b want=1", ReleaseErr); end
    total++; if (FreeCount !== m_free() || OldestTag !== m_oldest()) begin bad++; $display("FAIL wrap_state free=%0d oldest=%h want=%0d,%h (before %0d,%h)", FreeCount, OldestTag, m_free(), m_oldest(), fc, ot); end
    tick();
    total++; if (ReleaseErr !== 1'b0) begin bad++; $display("FAIL wrap_err_pulse got=%b want=0", ReleaseErr); end
  endtask

  task automatic test_full_release();
    do_reset();
    for (int i = 0; i < 32; i++) begin drive(1, 4'(i), 0, 0); tick(); end
    drive(1, 0, 1, 6'h00);
    total++; if (AllocACK !== 1'b0) begin bad++; $display("FAIL fr_ack0 got=%b want=0", AllocACK); end
    tick();
    drive(1, 0, 0, 0);
    total++; if (AllocACK !== 1'b0 || ReleaseErr !== 1'b0) begin bad++; $display("FAIL fr_ack1 ack=%b err=%b want=0,0", AllocACK, ReleaseErr); end
    tick();
    total++; if (AllocACK !== 1'b1 || AllocTag !== 6'h20) begin bad++; $display("FAIL fr_grant ack=%b tag=%h want=1,20", AllocACK, AllocTag); end
    tick();
    drive(0, 0, 0, 0);
  endtask

`ifdef MEM_WRITEBACK_TAG_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, 4'(i), 0, 0); tick(); end
    Flush = 1;
    drive(1, 4'd9, 1, 6'd2);
    total++; if (AllocACK !== 1'b0) begin bad++; $display("FAIL flush_ack got=%b want=0", AllocACK); end
    tick();
    Flush = 0;
    drive(1, 0, 0, 0);
    total++; if (Empty !== 1'b1 || ReleaseErr !== 1'b0 || RegPendingMask !== 16'h0) begin bad++; $display("FAIL flush_state empty=%b err=%b mask=%h want=1,0,0", Empty, ReleaseErr, RegPendingMask); end
    total++; if (AllocACK !== 1'b1 || AllocTag !== 6'd5) begin bad++; $display("FAIL flush_next ack=%b tag=%h want=1,05", AllocACK, AllocTag); end
    tick();
    drive(0, 0, 0, 0);
  endtask
`endif

  task automatic test_random();
    logic [5:0] rt;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      clk_en = ($urandom % 8) != 0;
      rt = (mq.size() > 0 && $urandom % 4 != 0) ? mq[$urandom % mq.size()].tag : 6'($urandom);
      drive(($urandom % 4) != 0, 4'($urandom), ($urandom % 2) == 0, rt);
      total++; if (AllocACK !== (clk_en && AllocREQ && mq.size() < 32) || AllocTag !== m_next) begin bad++; $display("FAIL rnd_alloc c=%0d ack=%b tag=%h want tag=%h", c, AllocACK, AllocTag, m_next); end
      tick();
      total++; if (FreeCount !== m_free() || Full !== (mq.size() == 32) || Empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_count c=%0d free=%0d full=%b empty=%b want free=%0d", c, FreeCount, Full, Empty, m_free()); end
      total++; if (OldestTag !== m_oldest() || RegPendingMask !== m_mask()) begin bad++; $display("FAIL rnd_age c=%0d oldest=%h mask=%h want=%h,%h", c, OldestTag, RegPendingMask, m_oldest(), m_mask()); end
      total++; if (ReleaseErr !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, ReleaseErr, m_err); end
    end
    clk_en = 1;
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_out_of_order();
    test_wrap();
    test_full_release();
`ifdef MEM_WRITEBACK_TAG_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
